// File: rtl/conv1d_qalc_sched.sv
// Pass scheduler for the conv1d quantised-accumulate engine.
// Walks (position, filter) pairs with filter as the inner loop, launches one
// qalc pass per pair, then offers each finished pass to write-back.
//
// state  | meaning
// IDLE   | waiting for start
// LAUNCH | start_qalc pulse for the current pair
// WAIT   | pass in flight, waiting for done_qalc
// EMIT   | result offered to write-back (out_valid)
// FINISH | one-cycle done pulse
// DRAIN  | aborted mid-pass, waiting for the uncancellable pass to end
module conv1d_qalc_sched #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_n_out,
  input  logic [CNT_W-1:0] cfg_n_filt,
  output logic             start_qalc,
  input  logic             done_qalc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_pos,
  output logic [CNT_W-1:0] out_filt,
  output logic             busy,
  output logic             done,
  output logic             err_cfg,
  output logic             aborted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_EMIT   = 3'd3,
    S_FINISH = 3'd4,
    S_DRAIN  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] filt_q, filt_d;
  logic [CNT_W-1:0] n_out_q, n_out_d;
  logic [CNT_W-1:0] n_filt_q, n_filt_d;
  logic             err_cfg_q, err_cfg_d;
  logic             aborted_q, aborted_d;

  logic             filt_last;
  logic             pair_last;

  assign filt_last = (filt_q == (n_filt_q - ONE));
  assign pair_last = filt_last && (pos_q == (n_out_q - ONE));

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pos_q     <= '0;
      filt_q    <= '0;
      n_out_q   <= '0;
      n_filt_q  <= '0;
      err_cfg_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      filt_q    <= filt_d;
      n_out_q   <= n_out_d;
      n_filt_q  <= n_filt_d;
      err_cfg_q <= err_cfg_d;
      aborted_q <= aborted_d;
    end
  end

  // Next-state and counter update; abort outranks every other transition.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    filt_d    = filt_q;
    n_out_d   = n_out_q;
    n_filt_d  = n_filt_q;
    err_cfg_d = err_cfg_q;
    aborted_d = aborted_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_out_d   = cfg_n_out;
          n_filt_d  = cfg_n_filt;
          pos_d     = '0;
          filt_d    = '0;
          aborted_d = 1'b0;
          if ((cfg_n_out == '0) || (cfg_n_filt == '0)) begin
            err_cfg_d = 1'b1;
            state_d   = S_FINISH;
          end else begin
            err_cfg_d = 1'b0;
            state_d   = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DRAIN;
        end else if (done_qalc) begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else if (out_ready) begin
          if (pair_last) begin
            // Counters hold on the final accept so they never wrap.
            state_d = S_FINISH;
          end else begin
            state_d = S_LAUNCH;
            if (filt_last) begin
              filt_d = '0;
              pos_d  = pos_q + ONE;
            end else begin
              filt_d = filt_q + ONE;
            end
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_DRAIN: begin
        if (done_qalc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign start_qalc = (state_q == S_LAUNCH);
  assign out_valid  = (state_q == S_EMIT);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FINISH);
  assign out_pos    = pos_q;
  assign out_filt   = filt_q;
  assign err_cfg    = err_cfg_q;
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_conv1d_qalc_sched.sv
// Randomised bench for conv1d_qalc_sched: a qalc responder, a write-back
// sink and an expected pair list built from nested loops.
module tb_conv1d_qalc_sched;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic [7:0] cfg_n_out;
  logic [7:0] cfg_n_filt;
  logic       start_qalc;
  logic       done_qalc;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_pos;
  logic [7:0] out_filt;
  logic       busy;
  logic       done;
  logic       err_cfg;
  logic       aborted;

  int n_checks = 0;
  int n_errors = 0;

  conv1d_qalc_sched #(.CNT_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .cfg_n_out  (cfg_n_out),
    .cfg_n_filt (cfg_n_filt),
    .start_qalc (start_qalc),
    .done_qalc  (done_qalc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pos    (out_pos),
    .out_filt   (out_filt),
    .busy       (busy),
    .done       (done),
    .err_cfg    (err_cfg),
    .aborted    (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start_qalc"}, {31'd0, start_qalc}, 0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_out_pos"}, {24'd0, out_pos}, 0);
    chk({tag, "_out_filt"}, {24'd0, out_filt}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_err_cfg"}, {31'd0, err_cfg}, 0);
    chk({tag, "_aborted"}, {31'd0, aborted}, 0);
  endtask

  // One run. Inputs are driven and outputs observed at the falling edge.
  // abort_idx: pass number to abort (-1 none); abort_emit selects EMIT vs WAIT.
  // reset_idx: pass number whose WAIT gets an asynchronous reset (-1 none).
  task automatic run_case(input int n_o, input int n_f, input int lat, input bit rdy_rand,
                          input int hold, input int abort_idx, input bit abort_emit,
                          input int reset_idx, input bit junk);
    int  exp_q[$];
    int  total, starts, accepts, cnt, hold_left, exp_pair;
    bit  zero_cfg, ended, aborting, idle_next, exp_sq, exp_ov, exp_done, prev_hold, first_wait;
    logic [7:0] hold_pos, hold_filt;

    zero_cfg = (n_o == 0) || (n_f == 0);
    for (int p = 0; p < n_o; p++)
      for (int f = 0; f < n_f; f++)
        exp_q.push_back((p << 8) | f);
    total = zero_cfg ? 0 : n_o * n_f;

    @(negedge clk);
    cfg_n_out  = 8'(n_o);
    cfg_n_filt = 8'(n_f);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 1);
    chk("launch_after_start", {31'd0, start_qalc}, {31'd0, !zero_cfg});
    if (zero_cfg) begin
      chk("zero_done", {31'd0, done}, 1);
      chk("zero_err_cfg", {31'd0, err_cfg}, 1);
      @(negedge clk);
      chk("zero_busy_end", {31'd0, busy}, 0);
      chk("zero_no_launch", {31'd0, start_qalc}, 0);
      chk("zero_err_sticky", {31'd0, err_cfg}, 1);
      return;
    end
    chk("err_cfg_cleared", {31'd0, err_cfg}, 0);
    chk("aborted_cleared", {31'd0, aborted}, 0);

    starts = 0; accepts = 0; cnt = 0; hold_left = hold;
    ended = 0; aborting = 0; idle_next = 0; exp_sq = 0; exp_ov = 0;
    exp_done = 0; prev_hold = 0; first_wait = 0;
    hold_pos = '0; hold_filt = '0;

    for (int cyc = 0; cyc < 3000 && !ended; cyc++) begin
      start = 1'b0; abort = 1'b0; done_qalc = 1'b0; out_ready = 1'b0;
      if (aborting) begin
        chk("abort_no_valid", {31'd0, out_valid}, 0);
        chk("abort_no_done", {31'd0, done}, 0);
        chk("abort_no_launch", {31'd0, start_qalc}, 0);
        if (idle_next) begin
          chk("abort_idle", {31'd0, busy}, 0);
          chk("aborted_flag", {31'd0, aborted}, 1);
          ended = 1;
        end else begin
          chk("drain_busy", {31'd0, busy}, 1);
          if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
              done_qalc = 1'b1;
              idle_next = 1;
            end
          end
        end
      end else begin
        chk("busy_run", {31'd0, busy}, 1);
        if (exp_sq) chk("launch_after_accept", {31'd0, start_qalc}, 1);
        if (exp_ov) chk("valid_after_done", {31'd0, out_valid}, 1);
        if (prev_hold) begin
          chk("valid_held", {31'd0, out_valid}, 1);
          chk("pos_stable", {24'd0, out_pos}, {24'd0, hold_pos});
          chk("filt_stable", {24'd0, out_filt}, {24'd0, hold_filt});
        end
        exp_sq = 0; exp_ov = 0; prev_hold = 0;
        if (done || exp_done) begin
          chk("done_pulse", {31'd0, done}, {31'd0, exp_done});
          chk("pass_count", accepts, total);
          chk("launch_total", starts, total);
          chk("aborted_clear", {31'd0, aborted}, 0);
          ended = 1;
        end else if (start_qalc) begin
          starts++;
          chk("launch_count", starts, accepts + 1);
          if (exp_q.size() > 0)
            chk("launch_pair", {16'd0, out_pos, out_filt}, exp_q[0]);
          cnt = lat;
          first_wait = 1;
        end else if (out_valid) begin
          if (abort_emit && abort_idx == accepts) begin
            abort = 1'b1;
            out_ready = 1'b1;
            aborting = 1;
            idle_next = 1;
          end else begin
            if (hold_left > 0) begin
              hold_left--;
              out_ready = 1'b0;
            end else if (rdy_rand) begin
              out_ready = 1'($urandom_range(0, 1));
            end else begin
              out_ready = 1'b1;
            end
            if (junk) done_qalc = 1'($urandom_range(0, 1));
            if (out_ready) begin
              exp_pair = exp_q.pop_front();
              chk("emit_pair", {16'd0, out_pos, out_filt}, exp_pair);
              accepts++;
              if (exp_q.size() == 0) exp_done = 1;
              else exp_sq = 1;
            end else begin
              prev_hold = 1;
              hold_pos  = out_pos;
              hold_filt = out_filt;
            end
          end
        end else if (cnt > 0) begin
          if (reset_idx == starts - 1) begin
            #2 reset_n = 1'b0;
            #1 chk_all_zero("async_reset");
            #1 reset_n = 1'b1;
            ended = 1;
          end else begin
            if (first_wait && !abort_emit && abort_idx == starts - 1) begin
              abort = 1'b1;
              aborting = 1;
            end
            cnt--;
            if (cnt == 0) begin
              done_qalc = 1'b1;
              if (!aborting) exp_ov = 1;
            end
          end
          first_wait = 0;
        end
        if (junk && !ended && !exp_done && !aborting) begin
          start      = 1'($urandom_range(0, 1));
          cfg_n_out  = 8'($urandom);
          cfg_n_filt = 8'($urandom);
        end
      end
      @(negedge clk);
    end
    chk("timeout", {31'd0, ended}, 1);
    start = 1'b0; abort = 1'b0; done_qalc = 1'b0; out_ready = 1'b0;
    chk("busy_end", {31'd0, busy}, 0);
    chk("done_end", {31'd0, done}, 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; done_qalc = 1'b0; out_ready = 1'b0;
    cfg_n_out = '0; cfg_n_filt = '0;
    #3 chk_all_zero("reset");
    #14 reset_n = 1'b1;

    run_case(2, 3, 5, 0, 0, -1, 0, -1, 0);
    run_case(1, 1, 2, 0, 7, -1, 0, -1, 0);
    run_case(4, 0, 1, 0, 0, -1, 0, -1, 0);
    run_case(1, 1, 1, 0, 0, -1, 0, -1, 0);
    run_case(2, 2, 4, 0, 0, 1, 0, -1, 0);
    run_case(2, 2, 2, 0, 0, 2, 1, -1, 0);

    // Stray done_qalc while idle must not start anything.
    @(negedge clk);
    done_qalc = 1'b1;
    @(negedge clk);
    done_qalc = 1'b0;
    chk("idle_stray_busy", {31'd0, busy}, 0);
    chk("idle_stray_launch", {31'd0, start_qalc}, 0);
    @(negedge clk);
    chk("idle_stray_valid", {31'd0, out_valid}, 0);

    for (int r = 0; r < 6; r++)
      run_case($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 4), 1, 0, -1, 0, -1, 1);

    run_case(2, 2, 3, 0, 0, -1, 0, 1, 0);
    run_case(2, 2, 1, 0, 0, -1, 0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
